// File: rtl/plru_repl_engine.sv
// Tree-PLRU replacement engine: per-set tree bits held in an internal array, serving
// touch, demote, victim and query requests one at a time through an INIT/IDLE/LOOKUP/COMMIT FSM.
module plru_repl_engine #(
    parameter int N_WAY = 16,
    parameter int N_SET = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [$clog2(N_SET)-1:0] req_set,
    input  logic [$clog2(N_WAY)-1:0] req_way,
    input  logic [N_WAY-1:0]         req_inv_mask,
    output logic                     rsp_valid,
    output logic [$clog2(N_WAY)-1:0] rsp_way
);

    localparam int WW = $clog2(N_WAY);
    localparam int SW = $clog2(N_SET);
    localparam int NB = N_WAY - 1;

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_DEMOTE = 2'b01;
    localparam logic [1:0] OP_VICTIM = 2'b10;
    localparam logic [1:0] OP_QUERY  = 2'b11;

    localparam logic [WW-1:0] ONE_W   = WW'(1);
    localparam logic [WW-1:0] TWO_W   = WW'(2);
    localparam logic [SW-1:0] LAST_SET = SW'(N_SET - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [SW-1:0]     init_cnt_r;
    logic [1:0]        op_r;
    logic [SW-1:0]     set_r;
    logic [WW-1:0]     way_r;
    logic [N_WAY-1:0]  mask_r;
    logic [NB-1:0]     bits_r;
    logic              ready_r;
    logic              rsp_valid_r;
    logic [WW-1:0]     rsp_way_r;
    logic [NB-1:0]     tree_mem_r [N_SET];

    logic              mem_we_s;
    logic [SW-1:0]     mem_addr_s;
    logic [NB-1:0]     mem_wdata_s;
    logic [WW-1:0]     pick_way_s;
    logic [WW-1:0]     rsp_way_s;
    logic [NB-1:0]     new_bits_s;

    // Walk from the root following the inverted bit at each node; the taken bits form the way.
    function automatic logic [WW-1:0] tree_victim(input logic [NB-1:0] bits);
        logic [WW-1:0] way;
        logic [WW-1:0] node;
        logic          b;
        way  = '0;
        node = '0;
        for (int i = 0; i < WW; i++) begin
            b             = ~bits[node];
            way[WW-1-i]   = b;
            node          = (node << 1'b1) + (b ? TWO_W : ONE_W);
        end
        return way;
    endfunction

    // Rewrite the nodes on the way's path: toward the way (touch) or away from it (demote).
    function automatic logic [NB-1:0] tree_update(input logic [NB-1:0] bits,
                                                   input logic [WW-1:0] way,
                                                   input logic          demote);
        logic [NB-1:0] nb;
        logic [WW-1:0] node;
        logic          b;
        nb   = bits;
        node = '0;
        for (int i = 0; i < WW; i++) begin
            b        = way[WW-1-i];
            nb[node] = b ^ demote;
            node     = (node << 1'b1) + (b ? TWO_W : ONE_W);
        end
        return nb;
    endfunction

    // Lowest-index invalid way; scanning downward lets the lowest set bit win.
    function automatic logic [WW-1:0] lowest_inv(input logic [N_WAY-1:0] mask);
        logic [WW-1:0] way;
        way = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            way = mask[i] ? WW'(i) : way;
        end
        return way;
    endfunction

    // Result and updated tree bits for the captured request.
    always_comb begin
        pick_way_s = (mask_r != {N_WAY{1'b0}}) ? lowest_inv(mask_r) : tree_victim(bits_r);
        rsp_way_s  = pick_way_s;
        new_bits_s = bits_r;
        case (op_r)
            OP_TOUCH: begin
                rsp_way_s  = way_r;
                new_bits_s = tree_update(bits_r, way_r, 1'b0);
            end
            OP_DEMOTE: begin
                rsp_way_s  = way_r;
                new_bits_s = tree_update(bits_r, way_r, 1'b1);
            end
            OP_VICTIM: begin
                rsp_way_s  = pick_way_s;
                new_bits_s = tree_update(bits_r, pick_way_s, 1'b0);
            end
            OP_QUERY: begin
                rsp_way_s  = pick_way_s;
                new_bits_s = bits_r;
            end
            default: begin
                rsp_way_s  = pick_way_s;
                new_bits_s = bits_r;
            end
        endcase
    end

    // Next-state and array write control.
    always_comb begin
        state_s     = state_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = set_r;
        mem_wdata_s = new_bits_s;
        case (state_r)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = init_cnt_r;
                mem_wdata_s = {NB{1'b0}};
                if (init_cnt_r == LAST_SET) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = ST_LOOKUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                state_s = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_s  = ST_IDLE;
                mem_we_s = (op_r != OP_QUERY);
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // State, request capture, tree-bit read and registered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            op_r        <= 2'b00;
            set_r       <= '0;
            way_r       <= '0;
            mask_r      <= '0;
            bits_r      <= '0;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_way_r   <= '0;
        end else begin
            state_r     <= state_s;
            ready_r     <= (state_s == ST_IDLE);
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + SW'(1);
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r   <= req_op;
                        set_r  <= req_set;
                        way_r  <= req_way;
                        mask_r <= req_inv_mask;
                    end
                end
                ST_LOOKUP: begin
                    bits_r <= tree_mem_r[set_r];
                end
                ST_COMMIT: begin
                    rsp_valid_r <= 1'b1;
                    rsp_way_r   <= rsp_way_s;
                end
                default: begin
                    init_cnt_r <= '0;
                end
            endcase
        end
    end

    // Tree-bit array; contents are meaningless until the init sweep completes.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            tree_mem_r[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_way   = rsp_way_r;

endmodule

// File: tb/tb_plru_repl_engine.sv
// Scoreboard bench for plru_repl_engine: expected ways and accept cycles are queued at
// accept and compared when rsp_valid pulses.
module tb_plru_repl_engine;

    localparam int N_WAY = 16;
    localparam int N_SET = 1024;
    localparam int WW    = 4;
    localparam int SW    = 10;

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_DEMOTE = 2'b01;
    localparam logic [1:0] OP_VICTIM = 2'b10;
    localparam logic [1:0] OP_QUERY  = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [SW-1:0]     req_set;
    logic [WW-1:0]     req_way;
    logic [N_WAY-1:0]  req_inv_mask;
    logic              rsp_valid;
    logic [WW-1:0]     rsp_way;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rsp_cnt  = 0;
    int last_acc = 0;
    logic [WW-1:0] exp_q [$];
    int            acc_q [$];

    plru_repl_engine #(.N_WAY(N_WAY), .N_SET(N_SET)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_set      (req_set),
        .req_way      (req_way),
        .req_inv_mask (req_inv_mask),
        .rsp_valid    (rsp_valid),
        .rsp_way      (rsp_way)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every completion pulse.
    always @(posedge clk) begin
        logic [WW-1:0] ew;
        int            ea;
        #1;
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                ew = exp_q.pop_front();
                ea = acc_q.pop_front();
                check_eq("rsp_way", 32'(rsp_way), 32'(ew));
                check_eq("rsp_latency", 32'(cyc - ea), 32'd2);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input int set, input int way,
                         input logic [N_WAY-1:0] mask, input int exp_way, input bit push);
        int tmo;
        @(negedge clk);
        req_op       = op;
        req_set      = SW'(set);
        req_way      = WW'(way);
        req_inv_mask = mask;
        req_valid    = 1'b1;
        tmo = 0;
        while (req_ready !== 1'b1 && tmo < 3000) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 3000) begin
            check_eq("accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            last_acc = cyc + 1;
            if (push) begin
                exp_q.push_back(WW'(exp_way));
                acc_q.push_back(cyc + 1);
            end
            @(posedge clk);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int tmo;
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_init();
        int cnt;
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < N_SET + 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_eq("init_cycles", 32'(cnt), 32'(N_SET));
    endtask

    initial begin
        int prev;
        int cnt0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 2'b00;
        req_set      = '0;
        req_way      = '0;
        req_inv_mask = '0;
        #2;
        check_eq("reset_ready", 32'(req_ready), 32'd0);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_rsp_way", 32'(rsp_way), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        // Fresh tree points at the highest way.
        issue(OP_QUERY, 5, 0, 16'h0000, 15, 1'b1);
        go_idle();
        drain();

        // Touch 15 flips the victim to 7; neighbouring set unaffected.
        issue(OP_TOUCH, 5, 15, 16'h0000, 15, 1'b1);
        issue(OP_QUERY, 5, 0, 16'h0000, 7, 1'b1);
        issue(OP_QUERY, 6, 0, 16'h0000, 15, 1'b1);
        go_idle();
        drain();

        for (int w = 0; w < N_WAY; w++) begin
            issue(OP_TOUCH, 9, w, 16'h0000, w, 1'b1);
        end
        issue(OP_QUERY, 9, 0, 16'h0000, 0, 1'b1);
        issue(OP_DEMOTE, 9, 3, 16'h0000, 3, 1'b1);
        issue(OP_QUERY, 9, 0, 16'h0000, 3, 1'b1);
        issue(OP_QUERY, 9, 0, 16'h0000, 3, 1'b1);
        go_idle();
        drain();

        // Invalid mask picks way 4 and touches it, so the tree walk avoids 4.
        issue(OP_VICTIM, 2, 0, 16'h0090, 4, 1'b1);
        issue(OP_QUERY, 2, 0, 16'h0000, 15, 1'b1);
        go_idle();
        drain();

        // Four queued requests with req_valid held high.
        cnt0 = rsp_cnt;
        issue(OP_TOUCH, 30, 5, 16'h0000, 5, 1'b1);
        prev = last_acc;
        issue(OP_DEMOTE, 30, 10, 16'h0000, 10, 1'b1);
        check_eq("accept_spacing", 32'(last_acc - prev), 32'd3);
        prev = last_acc;
        issue(OP_QUERY, 30, 0, 16'h0000, 10, 1'b1);
        check_eq("accept_spacing", 32'(last_acc - prev), 32'd3);
        prev = last_acc;
        issue(OP_QUERY, 30, 0, 16'h8000, 15, 1'b1);
        check_eq("accept_spacing", 32'(last_acc - prev), 32'd3);
        go_idle();
        drain();
        check_eq("b2b_rsp_count", 32'(rsp_cnt - cnt0), 32'd4);
        repeat (3) @(negedge clk);
        check_eq("rsp_way_hold", 32'(rsp_way), 32'd15);
        check_eq("rsp_valid_idle", 32'(rsp_valid), 32'd0);

        // Reset while the request sits in LOOKUP: no response, tree reinitialised.
        issue(OP_QUERY, 5, 0, 16'h0000, 0, 1'b0);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        cnt0      = rsp_cnt;
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("rst_no_rsp", 32'(rsp_cnt - cnt0), 32'd0);
        rst_n = 1'b1;
        wait_init();
        issue(OP_QUERY, 5, 0, 16'h0000, 15, 1'b1);
        go_idle();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
